// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_pkg : shared datapath widths and sequencer state encoding      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DIGIT_DEF = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic b_out;
    logic ovf;
    logic zero;
  } flags_t;

  // The unused encoding 2'd3 falls through to IDLE so a corrupted state self-recovers.
  function automatic logic [1:0] fsm_next(input logic [1:0] st,
                                          input logic       start,
                                          input logic       last);
    logic [1:0] nxt;
    case (st)
      S_IDLE:  nxt = start ? S_RUN : S_IDLE;
      S_RUN:   nxt = last ? S_DONE : S_RUN;
      S_DONE:  nxt = start ? S_RUN : S_IDLE;
      default: nxt = S_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sub_digit.sv
// +--------------------------------------------------------------------+
// | sub_digit : combinational DIGIT-bit ripple-borrow subtractor       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout,
  output logic             bmsb_in
);

  logic [DIGIT:0] chain;

  always_comb begin
    chain    = '0;
    d        = '0;
    chain[0] = bin;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]       = x[i] ^ y[i] ^ chain[i];
      chain[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & chain[i]);
    end
  end

  assign bout    = chain[DIGIT];
  assign bmsb_in = chain[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/sub16_seq.sv
// +--------------------------------------------------------------------+
// | sub16_seq : multi-cycle digit-serial subtractor with flags         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sub16_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  flags_t           flags_q, flags_d;

  logic [DIGIT-1:0]       sd_diff;
  logic                   sd_bout;
  logic                   sd_bmsb;
  logic                   accept;
  logic                   last_step;
  logic [WIDTH+DIGIT-1:0] work_cat;

  sub_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x      (a_q[DIGIT-1:0]),
    .y      (b_q[DIGIT-1:0]),
    .bin    (borrow_q),
    .d      (sd_diff),
    .bout   (sd_bout),
    .bmsb_in(sd_bmsb)
  );

  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_step = (state_q == S_RUN) && (cnt_q == LAST_CNT);
  // New digits enter at the top so digit 0 ends up in the LSBs after STEPS shifts.
  assign work_cat  = {sd_diff, work_q};

  always_comb begin
    state_d  = fsm_next(state_q, start, cnt_q == LAST_CNT);
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    flags_d  = flags_q;

    if (accept) begin
      a_d      = a;
      b_d      = b;
      borrow_d = b_in;
      cnt_d    = '0;
      work_d   = '0;
    end else if (state_q == S_RUN) begin
      a_d      = a_q >> DIGIT;
      b_d      = b_q >> DIGIT;
      borrow_d = sd_bout;
      cnt_d    = cnt_q + 1'b1;
      work_d   = work_cat[WIDTH+DIGIT-1:DIGIT];
      if (last_step) begin
        diff_d        = work_cat[WIDTH+DIGIT-1:DIGIT];
        flags_d.b_out = sd_bout;
        flags_d.ovf   = sd_bmsb ^ sd_bout;
        flags_d.zero  = (work_cat[WIDTH+DIGIT-1:DIGIT] == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      flags_q  <= flags_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign diff  = diff_q;
  assign b_out = flags_q.b_out;
  assign ovf   = flags_q.ovf;
  assign zero  = flags_q.zero;

endmodule

`default_nettype wire

// File: tb/tb_sub16_seq.sv
// +--------------------------------------------------------------------+
// | tb_sub16_seq : directed self-checking bench for sub16_seq          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sub16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        b_out;
  logic        ovf;
  logic        zero;

  int n_chk  = 0;
  int n_pass = 0;

  sub16_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .diff (diff),
    .b_out(b_out),
    .ovf  (ovf),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Counts falling edges until done is seen; 99 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) n = 99;
  endtask

  task automatic check_result(input string tag, input logic [15:0] ed, input logic eb,
                              input logic eo, input logic ez);
    check({tag, ".diff"}, {16'h0, diff}, {16'h0, ed});
    check({tag, ".bout"}, {31'h0, b_out}, {31'h0, eb});
    check({tag, ".ovf"},  {31'h0, ovf},   {31'h0, eo});
    check({tag, ".zero"}, {31'h0, zero},  {31'h0, ez});
    check({tag, ".busy_in_done"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic op_check(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tbin, input logic [15:0] ed, input logic eb,
                          input logic eo, input logic ez);
    int n;
    @(negedge clk);
    a = ta; b = tb_v; b_in = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; b_in = 1'b1;
    check({tag, ".busy"}, {31'h0, busy}, 32'h1);
    wait_done(n);
    check({tag, ".lat"}, n, 32'd4);
    check_result(tag, ed, eb, eo, ez);
    @(negedge clk);
    check({tag, ".done_pulse"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int dcnt;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", {31'h0, busy}, 32'h0);
    check("rst.done", {31'h0, done}, 32'h0);
    check_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    op_check("T1",  16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    op_check("T2",  16'h0003, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    op_check("T3a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    op_check("T3b", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    op_check("T4a", 16'hAAAA, 16'h5555, 1'b0, 16'h5555, 1'b0, 1'b1, 1'b0);
    op_check("T4b", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // T5a: a second start mid-run must be dropped
    @(negedge clk);
    a = 16'h1234; b = 16'h0034; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("T5a.hold_diff", {16'h0, diff}, 32'h0000FFFF);
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("T5a.lat", n, 32'd2);
    check_result("T5a", 16'h1200, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("T5a.no_queue", {31'h0, busy}, 32'h0);

    // T5b: start held through DONE chains the next op with no idle gap
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("T5b.lat1", n, 32'd4);
    check_result("T5b1", 16'hFFF0, 1'b1, 1'b0, 1'b0);
    a = 16'h7FFF; b = 16'hFFFF; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("T5b.b2b_busy", {31'h0, busy}, 32'h1);
    check("T5b.b2b_done", {31'h0, done}, 32'h0);
    check("T5b.hold", {16'h0, diff}, 32'h0000FFF0);
    wait_done(n);
    check("T5b.lat2", n, 32'd4);
    check_result("T5b2", 16'h8000, 1'b1, 1'b1, 1'b0);

    // T6: asynchronous reset in the second RUN cycle aborts the op
    @(negedge clk);
    a = 16'h0009; b = 16'h0001; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("T6.busy", {31'h0, busy}, 32'h0);
    check("T6.done", {31'h0, done}, 32'h0);
    check("T6.diff", {16'h0, diff}, 32'h0);
    check("T6.bout", {31'h0, b_out}, 32'h0);
    check("T6.ovf",  {31'h0, ovf},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("T6.no_done", dcnt, 32'd0);
    op_check("T6post", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
